// File: rtl/accel_arb_pkg.sv
// Shared types and widths for the accelerator data-memory arbiter.
// Line read is 512 bits, word write is 32 bits, all addresses 16 bits.
package accel_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  localparam int ACC_ADDR_W  = 16;
  localparam int ACC_WDATA_W = 32;
  localparam int ACC_LINE_W  = 512;

endpackage

// File: rtl/accel_rr_picker.sv
// Round-robin search: first requesting core at or after rr_ptr_i, wrapping.
// Purely combinational; found_o is low when no core requests.
module accel_rr_picker #(
  parameter int NUM_ACC = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_ACC-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   idx_o
);

  int j;

  // Walk from the farthest offset down so the nearest hit to rr_ptr_i wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    for (int i = NUM_ACC - 1; i >= 0; i--) begin
      j = int'(rr_ptr_i) + i;
      if (j >= NUM_ACC) begin
        j = j - NUM_ACC;
      end
      if (req_i[j]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/accel_mem_arbiter.sv
// Shares one accelerator data-memory port among NUM_ACC cores, one transaction
// outstanding, round-robin grant, per-core completion, watchdog abort on silence.
module accel_mem_arbiter
  import accel_arb_pkg::*;
#(
  parameter int NUM_ACC = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_ACC-1:0]            acc_read_en,
  input  logic [NUM_ACC*ACC_ADDR_W-1:0] acc_read_addr,
  input  logic [NUM_ACC-1:0]            acc_write_en,
  input  logic [NUM_ACC*ACC_ADDR_W-1:0] acc_write_addr,
  input  logic [NUM_ACC*ACC_WDATA_W-1:0] acc_write_data,
  output logic [ACC_LINE_W-1:0]         acc_read_data,
  output logic [NUM_ACC-1:0]            acc_read_data_valid,
  output logic [NUM_ACC-1:0]            acc_write_done,
  output logic [NUM_ACC-1:0]            acc_err,
  output logic                          mem_acc_read_en,
  output logic [ACC_ADDR_W-1:0]         mem_acc_read_addr,
  output logic                          mem_acc_write_en,
  output logic [ACC_ADDR_W-1:0]         mem_acc_write_addr,
  output logic [ACC_WDATA_W-1:0]        mem_acc_write_data,
  input  logic [ACC_LINE_W-1:0]         mem_acc_read_data,
  input  logic                          mem_acc_read_data_valid,
  input  logic                          mem_acc_write_done,
  output logic                          arb_timeout
);

  localparam int IDX_W  = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
  localparam int WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_ACC - 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  arb_state_t              state_q, state_d;
  logic [IDX_W-1:0]        rr_ptr_q;
  logic [IDX_W-1:0]        grant_q;
  logic                    is_read_q;
  logic [ACC_ADDR_W-1:0]   addr_q;
  logic [ACC_WDATA_W-1:0]  wdata_q;
  logic [WDOG_W-1:0]       wdog_q;
  logic                    arb_timeout_q;

  logic [NUM_ACC-1:0]      req_vec;
  logic                    pick_found;
  logic [IDX_W-1:0]        pick_idx;
  logic                    rsp_hit;
  logic                    wdog_expire;
  logic                    txn_done;
  logic [IDX_W-1:0]        rr_next;
  logic [NUM_ACC-1:0]      grant_oh;

  assign req_vec = acc_read_en | acc_write_en;

  accel_rr_picker #(
    .NUM_ACC (NUM_ACC),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i    (req_vec),
    .rr_ptr_i (rr_ptr_q),
    .found_o  (pick_found),
    .idx_o    (pick_idx)
  );

  // Only the response type matching the latched op can finish a transaction;
  // a real response in the expiry cycle wins over the watchdog.
  assign rsp_hit     = (state_q == WAIT) &&
                       (is_read_q ? mem_acc_read_data_valid : mem_acc_write_done);
  assign wdog_expire = (state_q == WAIT) && !rsp_hit && (wdog_q == WDOG_LAST);
  assign txn_done    = rsp_hit || wdog_expire;
  assign rr_next     = (grant_q == IDX_LAST) ? '0 : grant_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_found) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (txn_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      is_read_q     <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wdog_q        <= '0;
      arb_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant_q   <= pick_idx;
            // Read has priority when a core raises both.
            is_read_q <= acc_read_en[pick_idx];
            addr_q    <= acc_read_en[pick_idx]
                         ? acc_read_addr[int'(pick_idx)*ACC_ADDR_W +: ACC_ADDR_W]
                         : acc_write_addr[int'(pick_idx)*ACC_ADDR_W +: ACC_ADDR_W];
            wdata_q   <= acc_write_data[int'(pick_idx)*ACC_WDATA_W +: ACC_WDATA_W];
          end
        end
        ISSUE: begin
          wdog_q <= '0;
        end
        WAIT: begin
          wdog_q <= wdog_q + 1'b1;
          if (txn_done) begin
            rr_ptr_q <= rr_next;
          end
          if (wdog_expire) begin
            arb_timeout_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    grant_oh          = '0;
    grant_oh[grant_q] = 1'b1;
  end

  // Completion pulses are combinational so they land in the response cycle.
  always_comb begin
    mem_acc_read_en     = 1'b0;
    mem_acc_write_en    = 1'b0;
    acc_read_data_valid = '0;
    acc_write_done      = '0;
    acc_err             = '0;
    if (state_q == ISSUE) begin
      mem_acc_read_en  = is_read_q;
      mem_acc_write_en = !is_read_q;
    end
    if (txn_done) begin
      if (is_read_q) begin
        acc_read_data_valid = grant_oh;
      end else begin
        acc_write_done = grant_oh;
      end
    end
    if (wdog_expire) begin
      acc_err = grant_oh;
    end
  end

  assign mem_acc_read_addr  = addr_q;
  assign mem_acc_write_addr = addr_q;
  assign mem_acc_write_data = wdata_q;
  assign acc_read_data      = mem_acc_read_data;
  assign arb_timeout        = arb_timeout_q;

endmodule

// File: tb/tb_accel_mem_arbiter.sv
// Directed bench for accel_mem_arbiter with four cores and an eight-cycle watchdog.
module tb_accel_mem_arbiter;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      acc_read_en, acc_write_en;
  logic [N*16-1:0]   acc_read_addr, acc_write_addr;
  logic [N*32-1:0]   acc_write_data;
  logic [511:0]      acc_read_data;
  logic [N-1:0]      acc_read_data_valid, acc_write_done, acc_err;
  logic              mem_acc_read_en, mem_acc_write_en;
  logic [15:0]       mem_acc_read_addr, mem_acc_write_addr;
  logic [31:0]       mem_acc_write_data;
  logic [511:0]      mem_acc_read_data;
  logic              mem_acc_read_data_valid, mem_acc_write_done;
  logic              arb_timeout;

  int checks = 0;
  int errors = 0;
  logic [511:0] line_a, line_b;

  always #5 clk = ~clk;

  accel_mem_arbiter #(.NUM_ACC(N), .TIMEOUT(8)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .acc_read_en             (acc_read_en),
    .acc_read_addr           (acc_read_addr),
    .acc_write_en            (acc_write_en),
    .acc_write_addr          (acc_write_addr),
    .acc_write_data          (acc_write_data),
    .acc_read_data           (acc_read_data),
    .acc_read_data_valid     (acc_read_data_valid),
    .acc_write_done          (acc_write_done),
    .acc_err                 (acc_err),
    .mem_acc_read_en         (mem_acc_read_en),
    .mem_acc_read_addr       (mem_acc_read_addr),
    .mem_acc_write_en        (mem_acc_write_en),
    .mem_acc_write_addr      (mem_acc_write_addr),
    .mem_acc_write_data      (mem_acc_write_data),
    .mem_acc_read_data       (mem_acc_read_data),
    .mem_acc_read_data_valid (mem_acc_read_data_valid),
    .mem_acc_write_done      (mem_acc_write_done),
    .arb_timeout             (arb_timeout)
  );

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    acc_read_en = '0; acc_write_en = '0;
    acc_read_addr = '0; acc_write_addr = '0; acc_write_data = '0;
    mem_acc_read_data = line_b;
    mem_acc_read_data_valid = 1'b0; mem_acc_write_done = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_acc_read_en, mem_acc_write_en} !== 2'b00)
      begin errors++; $display("FAIL reset_strobes got %b want 00", {mem_acc_read_en, mem_acc_write_en}); end
    checks++;
    if ({mem_acc_read_addr, mem_acc_write_addr, mem_acc_write_data} !== 64'h0)
      begin errors++; $display("FAIL reset_addr_data got %h want 0", {mem_acc_read_addr, mem_acc_write_addr, mem_acc_write_data}); end
    checks++;
    if ({acc_read_data_valid, acc_write_done, acc_err} !== 12'h0)
      begin errors++; $display("FAIL reset_pulses got %h want 000", {acc_read_data_valid, acc_write_done, acc_err}); end
    checks++;
    if (arb_timeout !== 1'b0)
      begin errors++; $display("FAIL reset_timeout got %b want 0", arb_timeout); end
    checks++;
    if (acc_read_data !== line_b)
      begin errors++; $display("FAIL reset_passthru got %h want %h", acc_read_data, line_b); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_all_writes;
    int exp_core[5];
    logic [15:0] exp_addr[5];
    logic [31:0] exp_data[5];
    int n_strobe = 0, n_done = 0, cur = 0;
    bit pend = 0, rearm = 0, first0 = 1;
    int drop_k;
    logic [N-1:0] exp_oh;
    exp_core = '{0, 1, 2, 3, 0};
    exp_addr = '{16'h2000, 16'h2001, 16'h2002, 16'h2003, 16'h2010};
    exp_data = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h200};
    next_cycle();
    for (int i = 0; i < N; i++) begin
      acc_write_addr[i*16 +: 16] = 16'h2000 + 16'(i);
      acc_write_data[i*32 +: 32] = 32'h100 + 32'(i);
    end
    acc_write_en = 4'hF;
    for (int c = 0; c < 60 && n_done < 5; c++) begin
      @(negedge clk);
      drop_k = -1;
      if (acc_write_done !== 4'b0000) begin
        exp_oh = 4'b0001 << exp_core[cur];
        checks++;
        if (acc_write_done !== exp_oh)
          begin errors++; $display("FAIL wr_done_%0d got %b want %b", n_done, acc_write_done, exp_oh); end
        drop_k = exp_core[cur];
        n_done++;
      end
      if (mem_acc_write_en === 1'b1) begin
        checks++;
        if (n_strobe >= 5) begin
          errors++; $display("FAIL wr_extra_strobe got %0d want 5", n_strobe + 1);
        end else if ({mem_acc_write_addr, mem_acc_write_data} !== {exp_addr[n_strobe], exp_data[n_strobe]}) begin
          errors++;
          $display("FAIL wr_order_%0d got %h/%h want %h/%h", n_strobe, mem_acc_write_addr,
                   mem_acc_write_data, exp_addr[n_strobe], exp_data[n_strobe]);
        end
        cur = (n_strobe < 5) ? n_strobe : 4;
        n_strobe++;
        pend = 1;
      end
      next_cycle();
      mem_acc_write_done = pend;
      pend = 0;
      if (rearm) begin
        acc_write_en[0] = 1'b1;
        acc_write_addr[15:0] = 16'h2010;
        acc_write_data[31:0] = 32'h200;
        rearm = 0;
      end
      if (drop_k >= 0) begin
        acc_write_en[drop_k] = 1'b0;
        if (drop_k == 0 && first0) begin first0 = 0; rearm = 1; end
      end
    end
    mem_acc_write_done = 1'b0;
    checks++;
    if (n_done != 5 || n_strobe != 5)
      begin errors++; $display("FAIL wr_counts got %0d/%0d want 5/5", n_strobe, n_done); end
  endtask

  task automatic test_read_core2;
    next_cycle();
    acc_read_en[2] = 1'b1;
    acc_read_addr[32 +: 16] = 16'h1000;
    @(negedge clk);
    checks++;
    if (mem_acc_read_en !== 1'b0)
      begin errors++; $display("FAIL rd_idle_strobe got %b want 0", mem_acc_read_en); end
    next_cycle(); @(negedge clk);
    checks++;
    if ({mem_acc_read_en, mem_acc_write_en, mem_acc_read_addr} !== {2'b10, 16'h1000})
      begin errors++; $display("FAIL rd_issue got %b%b %h want 10 1000", mem_acc_read_en, mem_acc_write_en, mem_acc_read_addr); end
    for (int c = 2; c <= 3; c++) begin
      next_cycle(); @(negedge clk);
      checks++;
      if ({mem_acc_read_en, acc_read_data_valid, mem_acc_read_addr} !== {5'b0, 16'h1000})
        begin errors++; $display("FAIL rd_wait_c%0d got %b %b %h want 0 0000 1000", c, mem_acc_read_en, acc_read_data_valid, mem_acc_read_addr); end
    end
    next_cycle();
    mem_acc_read_data = line_a;
    mem_acc_read_data_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (acc_read_data_valid !== 4'b0100)
      begin errors++; $display("FAIL rd_valid got %b want 0100", acc_read_data_valid); end
    checks++;
    if (acc_read_data !== line_a)
      begin errors++; $display("FAIL rd_data got %h want %h", acc_read_data, line_a); end
    checks++;
    if ({acc_write_done, acc_err} !== 8'h0)
      begin errors++; $display("FAIL rd_other got %b want 0", {acc_write_done, acc_err}); end
    next_cycle();
    mem_acc_read_data_valid = 1'b0;
    acc_read_en[2] = 1'b0;
    @(negedge clk);
    checks++;
    if ({acc_read_data_valid, mem_acc_read_en, mem_acc_write_en} !== 6'b0)
      begin errors++; $display("FAIL rd_after got %b want 0", {acc_read_data_valid, mem_acc_read_en, mem_acc_write_en}); end
  endtask

  task automatic test_read_write_core1;
    int n_rs = 0, n_ws = 0, n_v = 0, n_d = 0;
    bit pend_r = 0, pend_w = 0, drop_r = 0, drop_w = 0;
    next_cycle();
    acc_read_addr[16 +: 16]  = 16'h3000;
    acc_write_addr[16 +: 16] = 16'h3004;
    acc_write_data[32 +: 32] = 32'hDEADBEEF;
    acc_read_en[1] = 1'b1;
    acc_write_en[1] = 1'b1;
    mem_acc_read_data = line_b;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      drop_r = 0; drop_w = 0;
      if (mem_acc_read_en === 1'b1) begin
        n_rs++; pend_r = 1;
        checks++;
        if (n_ws != 0 || mem_acc_read_addr !== 16'h3000)
          begin errors++; $display("FAIL rw_read_issue got %h after %0d writes want 3000 first", mem_acc_read_addr, n_ws); end
      end
      if (mem_acc_write_en === 1'b1) begin
        n_ws++; pend_w = 1;
        checks++;
        if (n_rs != 1 || {mem_acc_write_addr, mem_acc_write_data} !== {16'h3004, 32'hDEADBEEF})
          begin errors++; $display("FAIL rw_write_issue got %h %h after %0d reads want 3004 deadbeef after 1", mem_acc_write_addr, mem_acc_write_data, n_rs); end
      end
      if (acc_read_data_valid !== 4'b0000) begin
        n_v++; drop_r = 1;
        checks++;
        if (acc_read_data_valid !== 4'b0010)
          begin errors++; $display("FAIL rw_valid got %b want 0010", acc_read_data_valid); end
      end
      if (acc_write_done !== 4'b0000) begin
        n_d++; drop_w = 1;
        checks++;
        if (acc_write_done !== 4'b0010)
          begin errors++; $display("FAIL rw_done got %b want 0010", acc_write_done); end
      end
      next_cycle();
      mem_acc_read_data_valid = pend_r; pend_r = 0;
      mem_acc_write_done = pend_w; pend_w = 0;
      if (drop_r) acc_read_en[1] = 1'b0;
      if (drop_w) acc_write_en[1] = 1'b0;
    end
    checks++;
    if ({n_rs, n_ws, n_v, n_d} !== {32'd1, 32'd1, 32'd1, 32'd1})
      begin errors++; $display("FAIL rw_counts got %0d %0d %0d %0d want 1 1 1 1", n_rs, n_ws, n_v, n_d); end
  endtask

  task automatic test_stray_wdone;
    next_cycle();
    acc_read_addr[48 +: 16] = 16'h4000;
    acc_read_en[3] = 1'b1;
    @(negedge clk);
    next_cycle(); @(negedge clk);
    checks++;
    if ({mem_acc_read_en, mem_acc_read_addr} !== {1'b1, 16'h4000})
      begin errors++; $display("FAIL stray_issue got %b %h want 1 4000", mem_acc_read_en, mem_acc_read_addr); end
    next_cycle();
    mem_acc_write_done = 1'b1;
    @(negedge clk);
    checks++;
    if ({acc_read_data_valid, acc_write_done, acc_err} !== 12'h0)
      begin errors++; $display("FAIL stray_ignored got %h want 000", {acc_read_data_valid, acc_write_done, acc_err}); end
    next_cycle();
    mem_acc_write_done = 1'b0;
    mem_acc_read_data = line_a;
    mem_acc_read_data_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (acc_read_data_valid !== 4'b1000 || acc_read_data !== line_a)
      begin errors++; $display("FAIL stray_read_done got %b want 1000", acc_read_data_valid); end
    next_cycle();
    mem_acc_read_data_valid = 1'b0;
    acc_read_en[3] = 1'b0;
  endtask

  task automatic test_timeout;
    next_cycle();
    acc_write_addr[15:0] = 16'h6000;
    acc_write_data[31:0] = 32'h0BADF00D;
    acc_write_en[0] = 1'b1;
    @(negedge clk);
    next_cycle(); @(negedge clk);
    checks++;
    if ({mem_acc_write_en, mem_acc_write_addr, mem_acc_write_data} !== {1'b1, 16'h6000, 32'h0BADF00D})
      begin errors++; $display("FAIL to_issue got %b %h %h want 1 6000 0badf00d", mem_acc_write_en, mem_acc_write_addr, mem_acc_write_data); end
    for (int c = 2; c <= 8; c++) begin
      next_cycle(); @(negedge clk);
      checks++;
      if ({acc_read_data_valid, acc_write_done, acc_err, arb_timeout} !== 13'h0)
        begin errors++; $display("FAIL to_wait_c%0d got %b want 0", c, {acc_read_data_valid, acc_write_done, acc_err, arb_timeout}); end
    end
    next_cycle(); @(negedge clk);
    checks++;
    if ({acc_write_done, acc_err, acc_read_data_valid} !== 12'b0001_0001_0000)
      begin errors++; $display("FAIL to_expire got %b want 000100010000", {acc_write_done, acc_err, acc_read_data_valid}); end
    next_cycle();
    acc_write_en[0] = 1'b0;
    mem_acc_read_data_valid = 1'b1;
    mem_acc_write_done = 1'b1;
    for (int c = 10; c <= 11; c++) begin
      @(negedge clk);
      checks++;
      if (arb_timeout !== 1'b1)
        begin errors++; $display("FAIL to_sticky_c%0d got %b want 1", c, arb_timeout); end
      checks++;
      if ({acc_read_data_valid, acc_write_done, acc_err, mem_acc_read_en, mem_acc_write_en} !== 14'h0)
        begin errors++; $display("FAIL to_late_rsp_c%0d got %b want 0", c, {acc_read_data_valid, acc_write_done, acc_err}); end
      next_cycle();
    end
    mem_acc_read_data_valid = 1'b0;
    mem_acc_write_done = 1'b0;
  endtask

  task automatic test_reset_mid_wait;
    acc_read_addr[32 +: 16] = 16'h1000;
    acc_read_en[2] = 1'b1;
    @(negedge clk);
    next_cycle(); @(negedge clk);
    checks++;
    if ({mem_acc_read_en, mem_acc_read_addr} !== {1'b1, 16'h1000})
      begin errors++; $display("FAIL rst_issue got %b %h want 1 1000", mem_acc_read_en, mem_acc_read_addr); end
    next_cycle(); @(negedge clk);
    checks++;
    if (arb_timeout !== 1'b1)
      begin errors++; $display("FAIL rst_pre_sticky got %b want 1", arb_timeout); end
    next_cycle();
    mem_acc_read_data = line_a;
    mem_acc_read_data_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({acc_read_data_valid, acc_write_done, acc_err, mem_acc_read_en, mem_acc_write_en, arb_timeout} !== 15'h0)
      begin errors++; $display("FAIL rst_async_outputs got %b want 0", {acc_read_data_valid, acc_write_done, acc_err, mem_acc_read_en, mem_acc_write_en, arb_timeout}); end
    checks++;
    if ({mem_acc_read_addr, mem_acc_write_addr, mem_acc_write_data} !== 64'h0 || acc_read_data !== line_a)
      begin errors++; $display("FAIL rst_async_data got %h want 0", {mem_acc_read_addr, mem_acc_write_addr, mem_acc_write_data}); end
    acc_read_addr[15:0] = 16'h5000;
    acc_read_en[0] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (acc_read_data_valid !== 4'b0000)
      begin errors++; $display("FAIL rst_stale_rsp got %b want 0000", acc_read_data_valid); end
    next_cycle();
    mem_acc_read_data_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_acc_read_en, mem_acc_read_addr} !== {1'b1, 16'h5000})
      begin errors++; $display("FAIL rst_grant0 got %b %h want 1 5000", mem_acc_read_en, mem_acc_read_addr); end
    next_cycle();
    mem_acc_read_data = line_b;
    mem_acc_read_data_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (acc_read_data_valid !== 4'b0001)
      begin errors++; $display("FAIL rst_core0_valid got %b want 0001", acc_read_data_valid); end
    next_cycle();
    mem_acc_read_data_valid = 1'b0;
    acc_read_en[0] = 1'b0;
    @(negedge clk);
    next_cycle(); @(negedge clk);
    checks++;
    if ({mem_acc_read_en, mem_acc_read_addr} !== {1'b1, 16'h1000})
      begin errors++; $display("FAIL rst_core2_next got %b %h want 1 1000", mem_acc_read_en, mem_acc_read_addr); end
    next_cycle();
    mem_acc_read_data_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (acc_read_data_valid !== 4'b0100)
      begin errors++; $display("FAIL rst_core2_valid got %b want 0100", acc_read_data_valid); end
    next_cycle();
    mem_acc_read_data_valid = 1'b0;
    acc_read_en[2] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit got expired want finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    line_a = {16{32'hA5A5A5A5}};
    line_b = {16{32'h5A0F1E2D}};
    test_reset();
    test_all_writes();
    test_read_core2();
    test_read_write_core1();
    test_stray_wdone();
    test_timeout();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
